shift_reg_seq: RTL and testbench
================================

Name: shift_reg_seq

Overview:
- Parametrised multi-mode shift register with a command handshake.
- Each accepted command either loads a parallel word or performs N single-bit shift/rotate steps, one per clock.
- A one-cycle done pulse marks completion.
- Used as the datapath serialiser/rotator behind bus-side control logic; generalises the fixed-width rotate-right register.

Parameters:
- WIDTH, 10, data register width in bits (≥2).
- CNT_W, 8, width of the step-count field; a command may request up to 2^CNT_W-1 steps.
- RESET_VAL, 0, value loaded into data_out on reset (WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_op  input  3  operation code, see Behaviour.
- cmd_cnt  input  CNT_W  number of single-bit steps for shift/rotate ops.
- load_data  input  WIDTH  parallel data for LOAD.
- ser_in  input  1  serial fill bit for SHL/SHR, sampled on every step edge.
- data_out  output  WIDTH  register contents.
- ser_out  output  1  bit expelled by the most recent step.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=RESET_VAL; ser_out=0.
  - State IDLE, so cmd_ready=1, busy=0, done=0.
  - Step counter cleared.
  - Reset mid-command aborts it; no done is issued.
- Opcodes:
  - 0 NOP.
  - 1 LOAD.
  - 2 SHL: {d[W-2:0],ser_in}, out=d[W-1].
  - 3 SHR: {ser_in,d[W-1:1]}, out=d[0].
  - 4 ROL: {d[W-2:0],d[W-1]}, out=d[W-1].
  - 5 ROR: {d[0],d[W-1:1]}, out=d[0].
  - 6 ASR: {d[W-1],d[W-1:1]}, out=d[0].
  - 7 reserved, executed as NOP.
- FSM states: IDLE, RUN, DONE.
  - cmd_ready = (state==IDLE); busy = (state==RUN); done = (state==DONE).
  - Accept occurs on the edge where cmd_valid && cmd_ready. cmd_valid while not ready is ignored; no queueing.
- IDLE, on accept:
  - LOAD: data_out<=load_data on the accept edge, ser_out unchanged, go to DONE. cmd_cnt is ignored.
  - NOP/reserved, or a shift op with cmd_cnt=0: go to DONE, no data change.
  - Shift op with cmd_cnt=N>0: latch op, remaining<=N, go to RUN.
- RUN:
  - Every edge applies one step and updates ser_out; remaining decrements.
  - The edge with remaining==1 performs the last step and goes to DONE.
  - N steps occupy N cycles.
- DONE: lasts exactly one cycle, then IDLE. The next command is acceptable the cycle after done.
- Timing: shift of N accepted at edge 0 → steps on edges 1..N, done high between edges N and N+1, cmd_ready high again after edge N+1.
- N>WIDTH is legal:
  - Rotates wrap modulo WIDTH naturally.
  - SHL/SHR fully refill from ser_in.
  - ASR saturates to all-sign.
- cmd_op, load_data and cmd_cnt are only sampled on the accept edge. ser_in is live, sampled each step edge.
- data_out is stable outside step/load edges.

Optional Feature:
- Macro SHIFT_REG_SEQ_PARITY_EN.
- Defined: adds output par_out (1 bit), a registered even parity (XOR reduction) of the value data_out takes on each update. Reset value is the parity of RESET_VAL. It always equals ^data_out with zero lag.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package shift_reg_seq_pkg:
  - Opcode localparams OP_NOP..OP_ASR and OP_RSVD.
  - State encoding IDLE/RUN/DONE.
- Sub-module shift_reg_step: purely combinational single-step network (op, d, ser_in → next_d, out_bit). Instantiated once by shift_reg_seq.

Test Plan:
- WIDTH=10, RESET_VAL=10'h155: release reset → data_out=10'h155, cmd_ready=1, busy=0, done=0, ser_out=0.
- LOAD 10'h3A5 → data_out=10'h3A5 the cycle after accept. done pulses one cycle later than accept; cmd_ready returns the cycle after done.
- data 10'h001, ROR cnt=1 → data_out=10'h200, ser_out=1. Then ROL cnt=10 → data_out=10'h200 unchanged. done arrives 11 cycles after accept, busy high for 10 cycles.
- data 10'h200, ASR cnt=3 → 10'h3C0, ser_out=0. Then SHL cnt=4 with ser_in=1 → 10'h00F.
- Shift cnt=0 and op 7 → done one cycle after accept, data unchanged. cmd_valid held during RUN → no second accept until IDLE.
- Assert rst_n low mid-RUN of ROR cnt=8 → data_out=RESET_VAL immediately, no done pulse, cmd_ready=1 after release. With SHIFT_REG_SEQ_PARITY_EN defined, par_out equals ^data_out at all times.

Source files
------------

// File: rtl/shift_reg_seq_pkg.sv
// Shared opcodes, FSM state type and opcode helper for shift_reg_seq.
package shift_reg_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // True for the opcodes that consume step cycles.
    function automatic logic is_step_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Combinational single-step shift/rotate network for shift_reg_seq.
module shift_reg_step
    import shift_reg_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] next_d_o,
    output logic             out_bit_o
);

    always_comb begin
        next_d_o  = d_i;
        out_bit_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                next_d_o  = {d_i[WIDTH-2:0], ser_i};
                out_bit_o = d_i[WIDTH-1];
            end
            OP_SHR: begin
                next_d_o  = {ser_i, d_i[WIDTH-1:1]};
                out_bit_o = d_i[0];
            end
            OP_ROL: begin
                next_d_o  = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
                out_bit_o = d_i[WIDTH-1];
            end
            OP_ROR: begin
                next_d_o  = {d_i[0], d_i[WIDTH-1:1]};
                out_bit_o = d_i[0];
            end
            OP_ASR: begin
                next_d_o  = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
                out_bit_o = d_i[0];
            end
            default: begin
                next_d_o  = d_i;
                out_bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Multi-mode shift register with command handshake and one-cycle done pulse.
// Optional par_out port enabled by defining SHIFT_REG_SEQ_PARITY_EN.
module shift_reg_seq
    import shift_reg_seq_pkg::*;
#(
    parameter int unsigned          WIDTH     = 10,
    parameter int unsigned          CNT_W     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
`ifdef SHIFT_REG_SEQ_PARITY_EN
    ,
    output logic             par_out
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_q, ser_d;
    logic [WIDTH-1:0] step_d;
    logic             step_out;

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i      (op_q),
        .d_i       (data_q),
        .ser_i     (ser_in),
        .next_d_o  (step_d),
        .out_bit_o (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= RESET_VAL;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        ser_d   = ser_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_DONE;
                    if (cmd_op == OP_LOAD) begin
                        data_d = load_data;
                    end else if (is_step_op(cmd_op) && (cmd_cnt != '0)) begin
                        op_d    = cmd_op;
                        cnt_d   = cmd_cnt;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                data_d = step_d;
                ser_d  = step_out;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        data_out  = data_q;
        ser_out   = ser_q;
    end

`ifdef SHIFT_REG_SEQ_PARITY_EN
    // Parity is registered from data_d so it tracks data_out with no lag.
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= ^RESET_VAL;
        end else begin
            par_q <= ^data_d;
        end
    end

    assign par_out = par_q;
`endif

endmodule

// File: tb/tb_shift_reg_seq.sv
// Randomised self-checking bench for shift_reg_seq against an arithmetic model.
module tb_shift_reg_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_cnt;
    logic [9:0] load_data;
    logic       ser_in;
    logic [9:0] data_out;
    logic       ser_out;
    logic       busy;
    logic       done;
`ifdef SHIFT_REG_SEQ_PARITY_EN
    logic       par_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_data;
    int m_ser;

    shift_reg_seq #(
        .WIDTH     (10),
        .CNT_W     (8),
        .RESET_VAL (10'h155)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .load_data (load_data),
        .ser_in    (ser_in),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
`ifdef SHIFT_REG_SEQ_PARITY_EN
        ,
        .par_out   (par_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: one step computed with plain arithmetic on a 10-bit value.
    function automatic void model_step(input int op, input int s);
        int d;
        d = m_data;
        case (op)
            2: begin m_ser = d / 512; m_data = (d * 2) % 1024 + s; end
            3: begin m_ser = d % 2;   m_data = d / 2 + s * 512; end
            4: begin m_ser = d / 512; m_data = (d * 2) % 1024 + d / 512; end
            5: begin m_ser = d % 2;   m_data = d / 2 + (d % 2) * 512; end
            6: begin m_ser = d % 2;   m_data = d / 2 + ((d >= 512) ? 512 : 0); end
            default: ;
        endcase
    endfunction

    function automatic logic pick_ser(input int mode);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return 1'($urandom % 2);
    endfunction

    task automatic check_data(input string tag);
        check_eq({tag, "_data"}, 32'(data_out), 32'(m_data));
        check_eq({tag, "_ser"}, 32'(ser_out), 32'(m_ser));
`ifdef SHIFT_REG_SEQ_PARITY_EN
        check_eq({tag, "_par"}, 32'(par_out), 32'($countones(m_data) % 2));
`endif
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("wait_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command and follow it cycle by cycle through RUN and DONE.
    task automatic run_cmd(input int op, input int cnt, input logic [9:0] ld,
                           input int ser_mode, input bit hold);
        int n;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_cnt   = 8'(cnt);
        load_data = ld;
        ser_in    = pick_ser(ser_mode);
        @(posedge clk); #1;
        if (op == 1) m_data = int'(ld);
        n = (op >= 2 && op <= 6) ? cnt : 0;
        // Scramble sampled-on-accept inputs; optionally keep valid asserted.
        cmd_op    = 3'($urandom);
        cmd_cnt   = 8'($urandom);
        load_data = 10'($urandom);
        cmd_valid = hold;
        for (int k = 0; k < n; k++) begin
            check_eq("run_busy", 32'(busy), 32'd1);
            check_eq("run_ready", 32'(cmd_ready), 32'd0);
            check_eq("run_done", 32'(done), 32'd0);
            ser_in = pick_ser(ser_mode);
            @(posedge clk); #1;
            model_step(op, int'(ser_in));
            check_data("step");
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_ready", 32'(cmd_ready), 32'd0);
        check_data("done");
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("post_done", 32'(done), 32'd0);
        check_eq("post_ready", 32'(cmd_ready), 32'd1);
        check_data("post");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        int cnt;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_cnt   = '0;
        load_data = '0;
        ser_in    = 1'b0;
        m_data    = 'h155;
        m_ser     = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_data", 32'(data_out), 32'h155);
        check_eq("rst_ser", 32'(ser_out), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_data("rst");

        run_cmd(1, 7, 10'h3A5, 0, 1'b0);
        check_eq("load_3a5", 32'(data_out), 32'h3A5);

        run_cmd(1, 0, 10'h001, 0, 1'b0);
        run_cmd(5, 1, 10'h0, 0, 1'b0);
        check_eq("ror1_data", 32'(data_out), 32'h200);
        check_eq("ror1_ser", 32'(ser_out), 32'd1);
        run_cmd(4, 10, 10'h0, 0, 1'b0);
        check_eq("rol10_data", 32'(data_out), 32'h200);

        run_cmd(6, 3, 10'h0, 0, 1'b0);
        check_eq("asr3_data", 32'(data_out), 32'h3C0);
        check_eq("asr3_ser", 32'(ser_out), 32'd0);
        run_cmd(2, 4, 10'h0, 2, 1'b0);
        check_eq("shl4_data", 32'(data_out), 32'h00F);

        run_cmd(3, 0, 10'h2AA, 0, 1'b0);
        run_cmd(7, 9, 10'h2AA, 0, 1'b0);
        run_cmd(0, 5, 10'h2AA, 0, 1'b0);
        check_eq("noop_data", 32'(data_out), 32'h00F);

        run_cmd(5, 12, 10'h0, 0, 1'b1);
        run_cmd(3, 255, 10'h0, 0, 1'b1);
        run_cmd(1, 0, 10'h2C3, 0, 1'b0);
        run_cmd(6, 15, 10'h0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 7));
            cnt = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 25));
            run_cmd(op, cnt, 10'($urandom), 0, 1'($urandom % 2));
        end

        // Abort a ROR of 8 partway through with an asynchronous reset.
        run_cmd(1, 0, 10'h0F0, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_cnt   = 8'd8;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            model_step(5, 0);
            check_data("abort_step");
        end
        rst_n = 1'b0;
        #1;
        m_data = 'h155;
        m_ser  = 0;
        check_eq("abort_data", 32'(data_out), 32'h155);
        check_eq("abort_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_data("abort");
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check_eq("after_abort_done", 32'(done), 32'd0);
            check_eq("after_abort_ready", 32'(cmd_ready), 32'd1);
            check_data("after_abort");
        end

        run_cmd(4, 13, 10'h0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
